// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the boot-loader state encoding.
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } boot_state_e;
endpackage

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program image into instruction memory and holds the core in reset until loaded.
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = 8,
  parameter int RELEASE_DLY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [XLEN-1:0]       s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  err_overflow,
  output logic [ADDR_WIDTH-2:0] word_count
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int WW = ADDR_WIDTH - 1;
  localparam int CW = $clog2(RELEASE_DLY + 1);
  boot_state_e state, nxt;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic hs, last_slot, clr;
  assign s_ready    = state == LOAD;
  assign hs         = s_valid & s_ready & ~abort;
  assign last_slot  = idx == IW'(DEPTH - 1);
  assign clr        = abort | (state == IDLE & start);
  assign core_rst_n = state == RUN;
  assign load_done  = state == RUN;
  always_comb begin
    nxt = abort                                  ? IDLE :
          state == IDLE && start                 ? LOAD :
          hs && s_last                           ? HOLD :
          hs && last_slot                        ? ERR  :
          state == HOLD && cnt == CW'(RELEASE_DLY) ? RUN  : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end
  // write port is a one-cycle-late copy of the accepted handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      idx          <= '0;
      word_count   <= '0;
      cnt          <= '0;
      err_overflow <= 1'b0;
    end else begin
      mem_we       <= hs;
      mem_addr     <= hs ? {idx, 2'b00} : mem_addr;
      mem_wdata    <= hs ? s_data : mem_wdata;
      cnt          <= (state == HOLD && nxt == HOLD) ? cnt + CW'(1) : '0;
      err_overflow <= abort ? 1'b0 : (state == LOAD && nxt == ERR) ? 1'b1 : err_overflow;
      if (clr) begin
        idx        <= '0;
        word_count <= '0;
      end else if (hs) begin
        idx        <= last_slot ? idx : idx + IW'(1);
        word_count <= word_count == WW'(DEPTH) ? word_count : word_count + WW'(1);
      end
    end
  end
endmodule
